// File: rtl/updown_ctrl_if.sv
// Button inputs and step/status outputs of the run/direction controller.
interface updown_ctrl_if;
  logic       btn_run;
  logic       btn_dir;
  logic [1:0] U_D;
  logic       running;
  logic       dir_down;

  // Stimulus / consumer side: drives raw buttons, observes outputs.
  modport master (
    output btn_run, btn_dir,
    input  U_D, running, dir_down
  );

  // Controller side.
  modport slave (
    input  btn_run, btn_dir,
    output U_D, running, dir_down
  );
endinterface

// File: rtl/updown_ctrl.sv
// Run/direction controller: conditions two raw buttons, tracks RUN/STOP and
// direction, and emits one-cycle U_D step commands every TICK_DIV cycles.
module updown_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         sys_rst_n,
  updown_ctrl_if.slave bus
);
  localparam int unsigned NB = 2;                       // 0: run, 1: dir
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] press;

  assign raw = {bus.btn_dir, bus.btn_run};

  generate
    for (genvar i = 0; i < NB; i++) begin : g_btn
      logic          s1, s2, db, db_d;
      logic [CW-1:0] cnt;

      // Synchronize, then accept a new level only after DB_CYCLES
      // consecutive samples that disagree with the current debounced level.
      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          s1   <= 1'b0;
          s2   <= 1'b0;
          db   <= 1'b0;
          db_d <= 1'b0;
          cnt  <= '0;
        end else begin
          s1   <= raw[i];
          s2   <= s1;
          db_d <= db;
          if (s2 == db) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            db  <= s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end

      // Rising edge of the debounced level only; releases are ignored.
      assign press[i] = db & ~db_d;
    end
  endgenerate

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    ud_q;
  logic          run_q;
  logic          dir_q;
  logic          tc;

  // Terminal count: last prescaler cycle of a RUN period.
  assign tc = (state == ST_RUN) && (presc == P_LAST);

  // Run/stop FSM, prescaler, direction flag and registered step output.
  // The step pulse is launched from the pre-edge direction, so a dir press
  // landing on the terminal count only affects later pulses.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_STOP;
      presc <= '0;
      ud_q  <= 2'b00;
      run_q <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      ud_q <= tc ? (dir_q ? 2'b11 : 2'b01) : 2'b00;
      if (press[1]) dir_q <= ~dir_q;
      case (state)
        ST_STOP: begin
          presc <= '0;
          if (press[0]) begin
            state <= ST_RUN;
            run_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (press[0]) begin
            state <= ST_STOP;
            run_q <= 1'b0;
            presc <= '0;
          end else begin
            presc <= tc ? '0 : presc + PW'(1);
          end
        end
        default: begin
          state <= ST_STOP;
          run_q <= 1'b0;
          presc <= '0;
        end
      endcase
    end
  end

  assign bus.U_D      = ud_q;
  assign bus.running  = run_q;
  assign bus.dir_down = dir_q;
endmodule

// File: tb/tb_updown_ctrl.sv
// Bench for updown_ctrl: directed scenarios with literal expectations plus
// randomized button activity compared every cycle against a behavioural model.
module tb_updown_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  updown_ctrl_if bus();

  updown_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model. Buttons: 2-sample delay, then a level is adopted once
  // it has disagreed with the accepted level for DB consecutive samples.
  // Steps: while running, a pulse follows every edge whose distance from the
  // RUN-entry edge is a positive multiple of TD.
  logic [1:0]  m_s1 = '0, m_s2 = '0, m_db = '0, m_db_d = '0;
  int          m_diff [2] = '{0, 0};
  logic        m_run = 1'b0, m_dir = 1'b0;
  logic [1:0]  m_ud = 2'b00;
  int unsigned m_n = 0, m_entry = 0;

  // Model state advance on every edge, cleared asynchronously by reset.
  always @(posedge clk or negedge sys_rst_n) begin : mdl
    logic [1:0]  raw, press, db_n;
    int          diff [2];
    int unsigned n, entry;
    logic        run, dir;
    logic [1:0]  ud;
    if (!sys_rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_db_d <= '0;
      m_diff[0] <= 0; m_diff[1] <= 0;
      m_run <= 1'b0; m_dir <= 1'b0; m_ud <= 2'b00;
      m_n <= 0; m_entry <= 0;
    end else begin
      raw   = {bus.btn_dir, bus.btn_run};
      press = m_db & ~m_db_d;
      n     = m_n + 1;
      ud    = (m_run && ((n - m_entry) % TD == 0)) ? (m_dir ? 2'b11 : 2'b01) : 2'b00;
      run   = m_run;
      entry = m_entry;
      dir   = m_dir;
      if (press[0]) begin
        if (m_run) run = 1'b0;
        else begin run = 1'b1; entry = n; end
      end
      if (press[1]) dir = ~m_dir;
      db_n = m_db;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_db[i]) begin
          diff[i] = m_diff[i] + 1;
          if (diff[i] == DB) begin
            db_n[i] = m_s2[i];
            diff[i] = 0;
          end
        end else begin
          diff[i] = 0;
        end
      end
      m_db_d <= m_db;
      m_db   <= db_n;
      m_diff[0] <= diff[0];
      m_diff[1] <= diff[1];
      m_s2   <= m_s1;
      m_s1   <= raw;
      m_run  <= run;
      m_dir  <= dir;
      m_entry <= entry;
      m_ud   <= ud;
      m_n    <= n;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare all outputs against the model.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp("model_ud", 32'(bus.U_D), 32'(m_ud));
      cmp("model_running", 32'(bus.running), 32'(m_run));
      cmp("model_dir_down", 32'(bus.dir_down), 32'(m_dir));
      checks++;
      if (bus.U_D == 2'b10) begin
        errors++;
        $display("FAIL ud_illegal: got 2 expected 0/1/3 at %0t", $time);
      end
    end
  endtask

  initial begin : stim
    int   rem_r, rem_d;
    logic found;
    bus.btn_run = 1'b0;
    bus.btn_dir = 1'b0;

    // Reset held with toggling buttons.
    for (int k = 0; k < 10; k++) begin
      bus.btn_run = k[0];
      bus.btn_dir = ~k[0];
      tick(1);
      cmp("lit_rst_ud", 32'(bus.U_D), 0);
      cmp("lit_rst_running", 32'(bus.running), 0);
      cmp("lit_rst_dir", 32'(bus.dir_down), 0);
    end
    bus.btn_run = 1'b0;
    bus.btn_dir = 1'b0;
    tick(1);
    sys_rst_n = 1'b1;
    tick(8);

    // Clean run press: running rises exactly 6 edges after the raw rise.
    bus.btn_run = 1'b1;
    tick(5);
    cmp("lit_press_lat5", 32'(bus.running), 0);
    tick(1);
    cmp("lit_press_lat6", 32'(bus.running), 1);
    bus.btn_run = 1'b0;
    // Up pulses at E+4, E+8, E+12.
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      cmp("lit_up_pulse", 32'(bus.U_D), (k % 4 == 0) ? 1 : 0);
    end
    // Direction press in RUN (now E+13): toggle at E+19, pulse E+20 is down.
    bus.btn_dir = 1'b1;
    tick(3);
    cmp("lit_up_e16", 32'(bus.U_D), 1);
    tick(2);
    cmp("lit_dir_e18", 32'(bus.dir_down), 0);
    tick(1);
    cmp("lit_dir_e19", 32'(bus.dir_down), 1);
    bus.btn_dir = 1'b0;
    tick(1);
    cmp("lit_down_e20", 32'(bus.U_D), 3);
    // Dir press landing on the terminal count of E+28: pulse keeps old dir.
    tick(2);
    bus.btn_dir = 1'b1;
    tick(5);
    cmp("lit_dir_e27", 32'(bus.dir_down), 1);
    bus.btn_dir = 1'b0;
    tick(1);
    cmp("lit_tc_dir_ud", 32'(bus.U_D), 3);
    cmp("lit_tc_dir_flag", 32'(bus.dir_down), 0);
    // Stop race: run press toggles at E+36, which is also a terminal count.
    tick(2);
    bus.btn_run = 1'b1;
    tick(2);
    cmp("lit_up_e32", 32'(bus.U_D), 1);
    tick(3);
    cmp("lit_run_e35", 32'(bus.running), 1);
    bus.btn_run = 1'b0;
    tick(1);
    cmp("lit_final_pulse", 32'(bus.U_D), 1);
    cmp("lit_stopped", 32'(bus.running), 0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      cmp("lit_stop_quiet", 32'(bus.U_D), 0);
    end
    // Restart: first pulse 4 cycles after re-entry.
    bus.btn_run = 1'b1;
    tick(4);
    bus.btn_run = 1'b0;
    tick(1);
    cmp("lit_restart_lat5", 32'(bus.running), 0);
    tick(1);
    cmp("lit_restart_lat6", 32'(bus.running), 1);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      cmp("lit_restart_pulse", 32'(bus.U_D), (k % 4 == 0) ? 1 : 0);
    end

    // Reset mid-run while U_D is 11.
    bus.btn_dir = 1'b1;
    tick(4);
    bus.btn_dir = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1);
      if (bus.U_D == 2'b11) found = 1'b1;
    end
    cmp("wait_ud11", 32'(found), 1);
    #1 sys_rst_n = 1'b0;
    #1;
    cmp("lit_async_ud", 32'(bus.U_D), 0);
    cmp("lit_async_running", 32'(bus.running), 0);
    cmp("lit_async_dir", 32'(bus.dir_down), 0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(8);

    // Bounce rejection: 1- and 2-cycle glitches must not toggle.
    bus.btn_run = 1'b1; tick(1); bus.btn_run = 1'b0; tick(3);
    bus.btn_run = 1'b1; tick(2); bus.btn_run = 1'b0; tick(3);
    bus.btn_run = 1'b1; tick(1); bus.btn_run = 1'b0; tick(1);
    bus.btn_run = 1'b1; tick(2); bus.btn_run = 1'b0; tick(8);
    cmp("lit_glitch_running", 32'(bus.running), 0);
    // Long hold: exactly one toggle.
    bus.btn_run = 1'b1;
    tick(50);
    cmp("lit_hold_running", 32'(bus.running), 1);
    bus.btn_run = 1'b0;
    tick(10);
    cmp("lit_release_running", 32'(bus.running), 1);

    // Randomized button activity with occasional asynchronous resets.
    rem_r = 0;
    rem_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rem_r == 0) begin
        bus.btn_run = 1'($urandom_range(0, 1));
        rem_r = $urandom_range(1, 10);
      end
      if (rem_d == 0) begin
        bus.btn_dir = ($urandom_range(0, 3) == 0);
        rem_d = $urandom_range(1, 12);
      end
      rem_r--;
      rem_d--;
      if ($urandom_range(0, 599) == 0) begin
        #2 sys_rst_n = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
      end
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
